// File: rtl/booth_mult_param.sv
// Sequential Booth multiplier with start/done handshake and signed/unsigned mode.
// Compile-time option: BOOTH_RADIX4_EN selects radix-4 recoding (default radix-2).
module booth_mult_param #(
    parameter int unsigned N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     mcand,
    input  logic [N-1:0]     mplier,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product,
    output logic [2:0]       S
);

`ifdef BOOTH_RADIX4_EN
    localparam int unsigned AW   = N + 3;
    localparam int unsigned QW   = N + 2;
    localparam int unsigned ITER = N / 2 + 1;
`else
    localparam int unsigned AW   = N + 2;
    localparam int unsigned QW   = N + 1;
    localparam int unsigned ITER = N + 1;
`endif
    localparam int unsigned PW = 2 * N;
    localparam int unsigned CW = $clog2(ITER + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        CALC = 3'd2,
        DONE = 3'd3
    } state_t;

    state_t state, state_next;
    logic busy_next, done_next;

    logic [N-1:0]  mcand_r, mplier_r;
    logic          signed_r;
    logic [AW-1:0] acc, m, addend, sum, step_acc;
    logic [QW-1:0] q, step_q;
    logic          q_1, step_q1;
    logic [CW-1:0] cnt;

    assign S = state;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: state_next = CALC;
            CALC: if (cnt == CW'(1)) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the upcoming state so busy/done come straight from flops
    always_comb begin
        busy_next = 1'b0;
        done_next = 1'b0;
        case (state_next)
            LOAD, CALC: busy_next = 1'b1;
            DONE:       done_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_next;
            done <= done_next;
        end
    end

    // One recode step: select addend from the multiplier's low bits, then arithmetic shift
    always_comb begin
        addend = '0;
`ifdef BOOTH_RADIX4_EN
        case ({q[1:0], q_1})
            3'b001, 3'b010: addend = m;
            3'b011:         addend = {m[AW-2:0], 1'b0};
            3'b100:         addend = -{m[AW-2:0], 1'b0};
            3'b101, 3'b110: addend = -m;
            default:        addend = '0;
        endcase
        sum      = acc + addend;
        step_acc = {{2{sum[AW-1]}}, sum[AW-1:2]};
        step_q   = {sum[1:0], q[QW-1:2]};
        step_q1  = q[1];
`else
        case ({q[0], q_1})
            2'b01:   addend = m;
            2'b10:   addend = -m;
            default: addend = '0;
        endcase
        sum      = acc + addend;
        step_acc = {sum[AW-1], sum[AW-1:1]};
        step_q   = {sum[0], q[QW-1:1]};
        step_q1  = q[0];
`endif
    end

    // Datapath: capture, extend, iterate, and latch the result on entry to DONE
    always_ff @(posedge clk) begin
        if (!rst) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            signed_r <= 1'b0;
            acc      <= '0;
            m        <= '0;
            q        <= '0;
            q_1      <= 1'b0;
            cnt      <= '0;
            product  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand_r  <= mcand;
                        mplier_r <= mplier;
                        signed_r <= is_signed;
                    end
                end
                LOAD: begin
                    acc <= '0;
                    m   <= {{(AW - N){signed_r & mcand_r[N-1]}}, mcand_r};
                    q   <= {{(QW - N){signed_r & mplier_r[N-1]}}, mplier_r};
                    q_1 <= 1'b0;
                    cnt <= CW'(ITER);
                end
                CALC: begin
                    acc <= step_acc;
                    q   <= step_q;
                    q_1 <= step_q1;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) product <= PW'({step_acc, step_q});
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_param.sv
// Directed self-checking bench for booth_mult_param at N=4.
module tb_booth_mult_param;

    localparam int unsigned N = 4;
`ifdef BOOTH_RADIX4_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 7;
`endif

    logic           clk, rst, start, is_signed;
    logic [N-1:0]   mcand, mplier;
    logic           busy, done;
    logic [2*N-1:0] product;
    logic [2:0]     S;

    int checks = 0;
    int errors = 0;

    booth_mult_param #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mcand(mcand), .mplier(mplier), .is_signed(is_signed),
        .busy(busy), .done(done), .product(product), .S(S)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full operation: accept, scramble inputs, wait for done, check latency/result/hold
    task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic sg, input logic [2*N-1:0] exp);
        int  edges;
        bit  seen;
        mcand = a; mplier = b; is_signed = sg; start = 1'b1;
        tick();
        check({tag, "_load_S"}, 32'(S), 32'd1);
        check({tag, "_load_busy"}, 32'(busy), 32'd1);
        start = 1'b0; mcand = ~a; mplier = ~b; is_signed = ~sg;
        edges = 1; seen = 1'b0;
        while (!seen && edges < 20) begin
            tick();
            edges++;
            if (done) seen = 1'b1;
            else check({tag, "_busy"}, 32'(busy), 32'd1);
        end
        check({tag, "_latency"}, 32'(edges), 32'(LAT));
        check({tag, "_product"}, 32'(product), 32'(exp));
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
        check({tag, "_done_S"}, 32'(S), 32'd3);
        tick();
        check({tag, "_idle_S"}, 32'(S), 32'd0);
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_held"}, 32'(product), 32'(exp));
    endtask

    logic [N-1:0]   a6 [3] = '{4'h3, 4'hF, 4'h7};
    logic [N-1:0]   b6 [3] = '{4'h5, 4'hF, 4'h8};
    logic           s6 [3] = '{1'b0, 1'b1, 1'b1};
    logic [2*N-1:0] e6 [3] = '{8'h0F, 8'h01, 8'hC8};

    initial begin
        int edges;
        int pulses;
        rst = 1'b0; start = 1'b0; mcand = '0; mplier = '0; is_signed = 1'b0;
        tick(); tick();
        check("rst_S", 32'(S), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        rst = 1'b1;
        tick();

        // Main function and boundaries
        run_op("s_m4x6",   4'hC, 4'h6, 1'b1, 8'hE8);
        run_op("s_2xm6",   4'h2, 4'hA, 1'b1, 8'hF4);
        run_op("s_m2xm7",  4'hE, 4'h9, 1'b1, 8'h0E);
        run_op("s_m8xm8",  4'h8, 4'h8, 1'b1, 8'h40);
        run_op("u_15x15",  4'hF, 4'hF, 1'b0, 8'hE1);
        run_op("u_8x8",    4'h8, 4'h8, 1'b0, 8'h40);
        run_op("s_0xm8",   4'h0, 4'h8, 1'b1, 8'h00);
        run_op("s_7x7",    4'h7, 4'h7, 1'b1, 8'h31);

        // start pulsed during CALC is ignored and not queued
        mcand = 4'hC; mplier = 4'h6; is_signed = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        mcand = 4'h7; mplier = 4'h3; is_signed = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        edges = 4;
        while (!done && edges < 20) begin
            tick();
            edges++;
        end
        check("ign_latency", 32'(edges), 32'(LAT));
        check("ign_product", 32'(product), 32'hE8);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) pulses++;
        end
        check("ign_extra_done", 32'(pulses), 32'd0);
        check("ign_held", 32'(product), 32'hE8);

        // Reset mid-CALC aborts the operation
        mcand = 4'h7; mplier = 4'h7; is_signed = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        check("abort_pre_S", 32'(S), 32'd2);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("abort_S", 32'(S), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        run_op("after_abort", 4'h7, 4'h7, 1'b1, 8'h31);

        // start held high: back-to-back operations
        mcand = a6[0]; mplier = b6[0]; is_signed = s6[0]; start = 1'b1;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            edges = 0;
            while (!done && edges < 20) begin
                tick();
                edges++;
            end
            if (done) pulses++;
            check($sformatf("b2b%0d_product", k), 32'(product), 32'(e6[k]));
            if (k < 2) begin
                mcand = a6[k+1]; mplier = b6[k+1]; is_signed = s6[k+1];
            end else begin
                start = 1'b0;
            end
            tick();
            check($sformatf("b2b%0d_idle_S", k), 32'(S), 32'd0);
            check($sformatf("b2b%0d_idle_held", k), 32'(product), 32'(e6[k]));
            if (k < 2) begin
                tick();
                check($sformatf("b2b%0d_load_S", k), 32'(S), 32'd1);
                check($sformatf("b2b%0d_load_held", k), 32'(product), 32'(e6[k]));
            end
        end
        check("b2b_pulses", 32'(pulses), 32'd3);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) pulses++;
        end
        check("b2b_no_extra", 32'(pulses), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
